tape_prefetch: RTL

TAPE_PREFETCH -- requirements
Module: tape_prefetch

---
 rtl/tape_pkg.sv | 15 +
 rtl/tape_fifo.sv | 57 +++++
 rtl/tape_prefetch.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/tape_pkg.sv
// Shared definitions for the tape image prefetcher: parameter defaults and
// the fetch sequencer state encoding.
package tape_pkg;

    localparam int AW_DEF        = 25;
    localparam int DEPTH_DEF     = 8;
    localparam int ACK_DELAY_DEF = 7;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } state_t;

endpackage

// File: rtl/tape_fifo.sv
// Show-ahead byte FIFO between the SDRAM fetch engine and the tape player.
// clear empties it in one cycle and takes priority over push and pop.
module tape_fifo
    import tape_pkg::*;
#(
    parameter int  DEPTH  = DEPTH_DEF,
    parameter int  DATA_W = 8,
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [PW:0]       count
);

    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/tape_prefetch.sv
// Streams a tape image out of SDRAM into a small FIFO, stealing one byte
// read per CPU refresh cycle so the CPU never sees contention.
module tape_prefetch
    import tape_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ACK_DELAY = ACK_DELAY_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    input  logic [AW-1:0] size,
    input  logic          nrfsh,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          empty,
    output logic          eof
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = ($clog2(ACK_DELAY + 1) > 1) ? $clog2(ACK_DELAY + 1) : 2;

    localparam logic [PW:0]   DEPTH_C  = DEPTH[PW:0];
    localparam logic [CW-1:0] CNT_LOAD = ACK_DELAY[CW-1:0];
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t        state, state_nxt;
    logic          mem_rd_nxt;
    logic [AW-1:0] mem_addr_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [AW-1:0] fetch_addr, fetch_addr_nxt;
    logic [AW-1:0] size_q, size_q_nxt;
    logic          fetch_push;
    logic          fifo_clear;
    logic          fifo_full;
    logic [PW:0]   fifo_count;

    logic          nrfsh_p0, nrfsh_p1, nrfsh_p2;
    logic          rfsh_high;
    logic          window_open;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            nrfsh_p0 <= 1'b1;
            nrfsh_p1 <= 1'b1;
            nrfsh_p2 <= 1'b1;
        end else begin
            nrfsh_p0 <= nrfsh;
            nrfsh_p1 <= nrfsh_p0;
            nrfsh_p2 <= nrfsh_p1;
        end
    end

    assign rfsh_high   = nrfsh_p1;
    assign window_open = nrfsh_p2 && !nrfsh_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            cnt        <= '0;
            fetch_addr <= '0;
            size_q     <= '0;
        end else begin
            state      <= state_nxt;
            mem_rd     <= mem_rd_nxt;
            mem_addr   <= mem_addr_nxt;
            cnt        <= cnt_nxt;
            fetch_addr <= fetch_addr_nxt;
            size_q     <= size_q_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        mem_rd_nxt     = mem_rd;
        mem_addr_nxt   = mem_addr;
        cnt_nxt        = cnt;
        fetch_addr_nxt = fetch_addr;
        size_q_nxt     = size_q;
        fetch_push     = 1'b0;
        fifo_clear     = 1'b0;

        if (restart) begin
            state_nxt      = IDLE;
            mem_rd_nxt     = 1'b0;
            fetch_addr_nxt = '0;
            size_q_nxt     = size;
            fifo_clear     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (window_open && (fetch_addr < size_q) && (fifo_count < DEPTH_C)) begin
                        state_nxt    = FETCH;
                        mem_rd_nxt   = 1'b1;
                        mem_addr_nxt = fetch_addr;
                        cnt_nxt      = CNT_LOAD;
                    end
                end
                FETCH: begin
                    // Refresh slot ended before the data arrived: drop this attempt.
                    if (rfsh_high) begin
                        state_nxt  = IDLE;
                        mem_rd_nxt = 1'b0;
                    end else if (cnt == CNT_ONE) begin
                        fetch_push     = 1'b1;
                        fetch_addr_nxt = fetch_addr + 1'b1;
                        mem_rd_nxt     = 1'b0;
                        state_nxt      = HOLD;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (rfsh_high) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    tape_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .clear  (fifo_clear),
        .push   (fetch_push && !fifo_full),
        .pop    (pop),
        .din    (mem_din),
        .dout   (dout),
        .empty  (empty),
        .full   (fifo_full),
        .count  (fifo_count)
    );

    assign eof = (fetch_addr == size_q) && empty;

endmodule
